display_scan: RTL

Time-multiplexed driver for the six-digit seven-segment clock display. It consumes the six decoded digit patterns produced by the HH:MM:SS counter's display7 decoders: seconds tens/units, minutes tens/units and hours tens/units. It drives a shared segment bus plus one enable per digit, so the board needs 8 + 6 pins instead of 48. A blanking gap between digits suppresses ghosting. Inputs are snapshotted once per frame so a counter update never tears a frame.

---
 rtl/display_scan.sv | 136 +++++++++++++
 1 files changed

// File: rtl/display_scan.sv
// rtl/display_scan.sv - six-digit multiplexed seven-segment scan driver with per-slot blanking
// Optional DISPLAY_SCAN_BRIGHTNESS_EN adds a 3-bit PWM brightness input on the digit enables.
module display_scan #(
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 8,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] segdec,
    input  logic [7:0] seg,
    input  logic [7:0] mindec,
    input  logic [7:0] min,
    input  logic [7:0] hordec,
    input  logic [7:0] hor,
    input  logic [5:0] dp,
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
    input  logic [2:0] bright,
`endif
    output logic [7:0] seg_o,
    output logic [5:0] an_o,
    output logic       frame_start
);

    localparam int             CW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]  CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [7:0]     SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic           DP_LIT    = (SEG_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic [5:0]     AN_OFF    = (AN_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [5:0][7:0] snap_q, snap_d;
    logic [7:0]      seg_out_q, seg_out_d;
    logic [5:0]      an_out_q, an_out_d;
    logic            frame_start_q, frame_start_d;

    logic [5:0][6:0] pats;
    logic            cnt_wrap;
    logic            take_snap;
    logic            on_phase;
    logic            an_en;

    // Bit 7 of each pattern carries nothing; the decimal point comes from dp.
    logic unused_bits;
    assign unused_bits = ^{segdec[7], seg[7], mindec[7], min[7], hordec[7], hor[7]};

`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
    logic [2:0] pw_q, pw_d;
    logic [2:0] bright_q, bright_d;
    logic [2:0] pw_cur;
`endif

    always_comb begin
        pats      = {hor[6:0], hordec[6:0], min[6:0], mindec[6:0], seg[6:0], segdec[6:0]};
        cnt_wrap  = (cnt_q == CNT_LAST);
        take_snap = (idx_q == 3'd0) && (cnt_q == '0);
        on_phase  = (cnt_q >= CNT_BLANK);

        cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_wrap) begin
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end

        // dp is stored already converted to output level so ON just forwards snap.
        snap_d = snap_q;
        if (take_snap) begin
            for (int d = 0; d < 6; d++) begin
                snap_d[d] = {(dp[d] ? DP_LIT : ~DP_LIT), pats[d]};
            end
        end
    end

`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
    always_comb begin
        bright_d = take_snap ? bright : bright_q;
        pw_cur   = (cnt_q == CNT_BLANK) ? 3'd0 : pw_q;
        pw_d     = on_phase ? pw_cur + 3'd1 : pw_q;
        an_en    = on_phase && (pw_cur <= bright_d);
    end
`else
    always_comb begin
        an_en = on_phase;
    end
`endif

    always_comb begin
        seg_out_d     = SEG_OFF;
        an_out_d      = AN_OFF;
        frame_start_d = take_snap;
        if (on_phase) begin
            seg_out_d = snap_d[idx_q];
        end
        if (an_en) begin
            an_out_d = AN_OFF ^ (6'd1 << idx_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= 3'd0;
            snap_q        <= {6{SEG_OFF}};
            seg_out_q     <= SEG_OFF;
            an_out_q      <= AN_OFF;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            snap_q        <= snap_d;
            seg_out_q     <= seg_out_d;
            an_out_q      <= an_out_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pw_q     <= 3'd0;
            bright_q <= 3'd0;
        end else begin
            pw_q     <= pw_d;
            bright_q <= bright_d;
        end
    end
`endif

    assign seg_o       = seg_out_q;
    assign an_o        = an_out_q;
    assign frame_start = frame_start_q;

endmodule
